instr_trace_buffer: RTL

Multi-lane MIPS instruction trace capture block, intended as a successor to the per-cycle text instruction logger. Each cycle it classifies the instruction words retired on LANES parallel lanes and keeps saturating per-class counters. It records the words into a DEPTH-entry circular buffer with a programmable match trigger and post-trigger window. After freezing, it drains the captured history oldest-first over a valid/ready port, for simulation monitors or debug readout.

---
 rtl/instr_trace_buffer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_trace_buffer.sv
// Multi-lane MIPS instruction trace capture: per-class retire counters plus a
// circular history buffer with match trigger, post-trigger window and ordered drain.
module instr_trace_buffer #(
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned POST  = 8,
   parameter int unsigned CNT_W = 32
) (
   input  logic                                     CLK,
   input  logic                                     RESET_n,
   input  logic [32*LANES-1:0]                      Instr,
   input  logic [LANES-1:0]                         Valid,
   input  logic                                     Clr,
   input  logic                                     Trig_En,
   input  logic [31:0]                              Trig_Val,
   input  logic [31:0]                              Trig_Mask,
   input  logic                                     Rd_Req,
   input  logic                                     Rd_Ready,
   output logic                                     Rd_Valid,
   output logic [34+((LANES > 1) ? $clog2(LANES) : 1):0] Rd_Data,
   output logic                                     Rd_Last,
   output logic [1:0]                               State,
   output logic [$clog2(DEPTH):0]                   Fill,
   input  logic [2:0]                               Cnt_Sel,
   output logic [CNT_W-1:0]                         Cnt_Out
);
   localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned FW = PW + 1;
   localparam int unsigned EW = 35 + LW;

   typedef enum logic [1:0] {
      S_ARMED  = 2'b00,
      S_POST   = 2'b01,
      S_FROZEN = 2'b10,
      S_DRAIN  = 2'b11
   } state_t;

   // Instruction class from opcode/funct; unlisted opcodes fall into class 7.
   function automatic logic [2:0] classify(input logic [31:0] w);
      logic [5:0] op;
      logic [5:0] fn;
      op = w[31:26];
      fn = w[5:0];
      classify = 3'd7;
      if (op == 6'b000000) begin
         if (fn == 6'b001000 || fn == 6'b001001)
            classify = 3'd1;
         else if ((fn >= 6'b010000 && fn <= 6'b010011) || (fn >= 6'b011000 && fn <= 6'b011011) ||
                  fn == 6'b001100 || fn == 6'b001101)
            classify = 3'd5;
         else
            classify = 3'd0;
      end else if (op == 6'b000001 || (op >= 6'b000010 && op <= 6'b000111) ||
                   (op >= 6'b010100 && op <= 6'b010110))
         classify = 3'd1;
      else if ((op >= 6'b100000 && op <= 6'b100110) || op == 6'b110000 || op == 6'b110001)
         classify = 3'd2;
      else if ((op >= 6'b101000 && op <= 6'b101011) || op == 6'b101110 || op == 6'b111000 ||
               op == 6'b111001)
         classify = 3'd3;
      else if (op == 6'b010001)
         classify = 3'd4;
      else if (op >= 6'b001000 && op <= 6'b001111)
         classify = 3'd6;
   endfunction

   state_t           state_q, state_d;
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [FW-1:0]    fill_q, fill_d, rem_q, rem_d, rdcnt_q, rdcnt_d;
   logic             rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
   logic [EW-1:0]    rd_data_q, rd_data_d;
   logic [CNT_W-1:0] cnt_q [8];
   logic [CNT_W-1:0] cnt_d [8];
   logic [CNT_W-1:0] cnt_out_q;
   logic [EW-1:0]    mem [DEPTH];

   logic [2:0]       lane_cls [LANES];
   logic [EW-1:0]    wdata [LANES];
   logic [PW-1:0]    waddr [LANES];
   logic [LANES-1:0] we;
   logic [FW-1:0]    n_wr;
   logic [FW:0]      fill_sum;
   logic             trig;
   logic [2:0]       inc [8];

   // Per-lane decode, trigger match and buffer entry formation.
   always_comb begin
      trig = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         lane_cls[k] = classify(Instr[32*k +: 32]);
         wdata[k]    = {lane_cls[k], LW'(k), Instr[32*k +: 32]};
         if (Trig_En && Valid[k] && (((Instr[32*k +: 32] ^ Trig_Val) & Trig_Mask) == 32'd0))
            trig = 1'b1;
      end
   end

   // Valid lanes packed into consecutive slots; POST stops writing once the window is used.
   always_comb begin
      we   = '0;
      n_wr = '0;
      for (int k = 0; k < LANES; k++) begin
         waddr[k] = wptr_q + PW'(n_wr);
         if (Valid[k] && !Clr &&
             (state_q == S_ARMED || (state_q == S_POST && n_wr < rem_q))) begin
            we[k] = 1'b1;
            n_wr  = n_wr + FW'(1);
         end
      end
   end

   // Saturating class counters; every valid lane counts regardless of state.
   always_comb begin
      for (int c = 0; c < 8; c++) inc[c] = 3'd0;
      for (int k = 0; k < LANES; k++)
         if (Valid[k]) inc[lane_cls[k]] = inc[lane_cls[k]] + 3'd1;
      for (int c = 0; c < 8; c++) begin
         logic [CNT_W:0] sum;
         sum = {1'b0, cnt_q[c]} + (CNT_W+1)'(inc[c]);
         cnt_d[c] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
         if (Clr) cnt_d[c] = '0;
      end
   end

   // Next-state and drain datapath.
   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q + PW'(n_wr);
      rptr_d     = rptr_q;
      rem_d      = rem_q;
      rdcnt_d    = rdcnt_q;
      rd_valid_d = rd_valid_q;
      rd_last_d  = rd_last_q;
      rd_data_d  = rd_data_q;
      fill_sum   = {1'b0, fill_q} + {1'b0, n_wr};
      fill_d     = (fill_sum >= (FW+1)'(DEPTH)) ? FW'(DEPTH) : fill_sum[FW-1:0];

      case (state_q)
         S_ARMED: begin
            if (trig) begin
               if (POST == 0) state_d = S_FROZEN;
               else begin
                  state_d = S_POST;
                  rem_d   = FW'(POST);
               end
            end
         end
         S_POST: begin
            rem_d = rem_q - n_wr;
            if (rem_d == '0) state_d = S_FROZEN;
         end
         S_FROZEN: begin
            if (Rd_Req) begin
               if (fill_q == '0) state_d = S_ARMED;
               else begin
                  state_d    = S_DRAIN;
                  rptr_d     = wptr_q - PW'(fill_q);
                  rdcnt_d    = FW'(1);
                  rd_valid_d = 1'b1;
                  rd_data_d  = mem[rptr_d];
                  rd_last_d  = (fill_q == FW'(1));
               end
            end
         end
         S_DRAIN: begin
            if (rd_valid_q && Rd_Ready) begin
               if (rd_last_q) begin
                  state_d    = S_ARMED;
                  fill_d     = '0;
                  wptr_d     = '0;
                  rd_valid_d = 1'b0;
                  rd_last_d  = 1'b0;
                  rd_data_d  = '0;
               end else begin
                  rptr_d    = rptr_q + PW'(1);
                  rdcnt_d   = rdcnt_q + FW'(1);
                  rd_data_d = mem[rptr_d];
                  rd_last_d = (rdcnt_d == fill_q);
               end
            end
         end
         default: state_d = S_ARMED;
      endcase

      if (Clr) begin
         state_d    = S_ARMED;
         wptr_d     = '0;
         rptr_d     = '0;
         fill_d     = '0;
         rem_d      = '0;
         rdcnt_d    = '0;
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
         rd_data_d  = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q    <= S_ARMED;
         wptr_q     <= '0;
         rptr_q     <= '0;
         fill_q     <= '0;
         rem_q      <= '0;
         rdcnt_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
         cnt_out_q  <= '0;
         for (int c = 0; c < 8; c++) cnt_q[c] <= '0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         fill_q     <= fill_d;
         rem_q      <= rem_d;
         rdcnt_q    <= rdcnt_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_data_q  <= rd_data_d;
         cnt_out_q  <= cnt_q[Cnt_Sel];
         for (int c = 0; c < 8; c++) cnt_q[c] <= cnt_d[c];
      end
   end

   // Trace storage carries no reset; Fill qualifies its contents.
   always_ff @(posedge CLK) begin
      for (int k = 0; k < LANES; k++)
         if (we[k]) mem[waddr[k]] <= wdata[k];
   end

   assign Rd_Valid = rd_valid_q;
   assign Rd_Data  = rd_data_q;
   assign Rd_Last  = rd_last_q;
   assign State    = state_q;
   assign Fill     = fill_q;
   assign Cnt_Out  = cnt_out_q;

endmodule
